pix_packer: RTL and testbench
=============================

// Module: pix_packer
// PURPOSE
//   Consumes the 12-bit pixel stream read out of the pixel async FIFO in the clk domain.
//   Packs pixels densely into 16-bit words: 4 pixels -> 3 words, LSB-first.
//   Drives the 16-bit word stream toward the RAM writer, with valid/ready on both sides.
//   Flushes and zero-pads on end-of-frame, and reports the pixel count of each frame.
// PARAMETERS
//   CountWidth   24   width of the per-frame pixel counter (wraps mod 2^CountWidth)
// PORTS
//   clk               in   1           system clock (PLL); all logic is on posedge clk
//   rst_n             in   1           asynchronous active-low reset
//   in_d              in   12          pixel data
//   in_valid          in   1           in_d valid
//   in_last           in   1           qualifies in_d as the final pixel of the frame
//   in_ready          out  1           block accepts the pixel; in_fire = in_valid & in_ready
//   out_d             out  16          packed word
//   out_valid         out  1           out_d valid
//   out_last          out  1           final word of the frame
//   out_ready         in   1           sink accepts; out_fire = out_valid & out_ready
//   frame_done        out  1           1-cycle pulse, cycle after the in_last pixel is accepted
//   frame_pixel_count out  CountWidth  pixels in the completed frame; held until next frame_done
// BEHAVIOUR
//   - Reset (rst_n=0, async): acc=0, acc_bits=0, state=RUN, counters=0.
//     out_valid, out_last, frame_done and frame_pixel_count are 0; out_d=0.
//     in_ready is 1 from the first clk after release.
//   - State: 40-bit accumulator acc, 6-bit acc_bits (0..40), 1-bit state RUN/FLUSH.
//   - All outputs are combinational from registered state only.
//     No ready->valid or valid->ready combinational paths.
//   - in_ready = (state==RUN) && (acc_bits <= 28).
//   - out_valid = (acc_bits >= 16) || (state==FLUSH && acc_bits > 0).
//   - out_d = acc[15:0]; bits at and above acc_bits are 0, which zero-pads the final word.
//   - Per clk update:
//       b' = acc_bits - (out_fire ? 16 : 0)
//       acc' = (out_fire ? acc>>16 : acc) | (in_fire ? in_d << b' : 0)
//       acc_bits' = b' + (in_fire ? 12 : 0)
//   - Simultaneous in_fire and out_fire is legal and is the steady state.
//     With out_ready=1 and in_valid=1, in_ready never drops: 1 pixel/clk, 0.75 word/clk.
//   - The first word is valid 2 clks after the first pixel is accepted (acc_bits reaches 24).
//   - Packing order: word0 = {p1[3:0], p0}; word1 = {p2[7:0], p1[11:4]}; word2 = {p3, p2[11:8]}.
//   - in_last: when in_fire && in_last, state -> FLUSH, so in_ready = 0 from the next clk.
//     - In FLUSH, out_last = (acc_bits <= 16); this is true only on the final word.
//     - On out_fire && out_last: state -> RUN, acc_bits -> 0.
//     - A frame ending exactly on a word boundary emits no pad word.
//   - Pixel counter: increments on every in_fire.
//     - On in_fire && in_last: frame_pixel_count <= count+1, counter <= 0,
//       frame_done pulses on the next clk.
//     - Counter wraps mod 2^CountWidth without error.
//   - Backpressure: while out_valid && !out_ready, out_d, out_valid and out_last hold stable.
//     Inputs stop being accepted once acc_bits > 28.
//   - in_valid without in_last is allowed indefinitely (frames of any length).
//   - A zero-pixel frame does not exist; in_last always travels with a pixel.
//   - rst_n asserted mid-frame or mid-flush discards all buffered bits immediately.
//     No out_last is produced for the aborted frame.
//   - in_d is ignored when !in_fire.
// TESTING
//   1. Pixels 0x123,0x456,0x789,0xABC, in_last on the 4th, out_ready=1 -> words 0x6123,0x8945,0xABC7;
//      out_last on 0xABC7 only; frame_done pulse; frame_pixel_count=4.
//   2. Single pixel 0xFFF with in_last -> one word 0x0FFF with out_last=1; frame_pixel_count=1.
//   3. 5 pixels of 0xFFF, in_last on the 5th -> words 0xFFFF,0xFFFF,0xFFFF,0x0FFF; out_last on 0x0FFF.
//   4. out_ready=0, in_valid=1 continuous -> exactly 3 pixels accepted (acc_bits=36), in_ready=0.
//      out_d is stable; release out_ready and the stream resumes with no loss or duplication.
//   5. 1024 pixels back-to-back, out_ready=1 -> in_ready never deasserts.
//      768 words out, out_last on the 768th, frame_pixel_count=1024.
//   6. rst_n pulsed low during FLUSH with 2 words pending -> outputs 0 at once.
//      The following 4-pixel frame reproduces test 1 exactly.

Source files
------------

// File: rtl/pix_packer.sv
// Packs a 12-bit pixel stream densely into 16-bit words, LSB-first (4 pixels -> 3 words).
// On end-of-frame the remainder is zero-padded and the frame's pixel count is reported.
module pix_packer #(
    parameter int CountWidth = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [11:0]           in_d,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [15:0]           out_d,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  frame_done,
    output logic [CountWidth-1:0] frame_pixel_count
);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                r_state;
    logic [39:0]           r_acc;
    logic [5:0]            r_bits;
    logic [CountWidth-1:0] r_count;
    logic [CountWidth-1:0] r_frame_count;
    logic                  r_frame_done;

    state_t                w_state_next;
    logic [39:0]           w_acc_next;
    logic [5:0]            w_bits_next;
    logic [5:0]            w_bits_after;
    logic                  w_in_fire;
    logic                  w_out_fire;

    assign in_ready          = (r_state == RUN) && (r_bits <= 6'd28);
    assign out_valid         = (r_bits >= 6'd16) || ((r_state == FLUSH) && (r_bits != 6'd0));
    assign out_last          = (r_state == FLUSH) && (r_bits <= 6'd16);
    assign out_d             = r_acc[15:0];
    assign frame_done        = r_frame_done;
    assign frame_pixel_count = r_frame_count;

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    always_comb begin
        w_state_next = r_state;
        w_bits_after = w_out_fire ? (r_bits - 6'd16) : r_bits;
        w_acc_next   = (w_out_fire ? (r_acc >> 16) : r_acc)
                     | (w_in_fire ? ({28'd0, in_d} << w_bits_after) : 40'd0);
        w_bits_next  = w_bits_after + (w_in_fire ? 6'd12 : 6'd0);
        if (w_in_fire && in_last) begin
            w_state_next = FLUSH;
        end
        // The final word may hold fewer than 16 bits; the subtraction above
        // wraps in that case, so the bit count is forced back to empty here.
        if (w_out_fire && out_last) begin
            w_state_next = RUN;
            w_bits_next  = 6'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_acc         <= '0;
            r_bits        <= '0;
            r_count       <= '0;
            r_frame_count <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_acc        <= w_acc_next;
            r_bits       <= w_bits_next;
            r_frame_done <= w_in_fire && in_last;
            if (w_in_fire) begin
                if (in_last) begin
                    r_frame_count <= r_count + 1'b1;
                    r_count       <= '0;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pix_packer.sv
// Directed bench for pix_packer: table of short frames with hand-packed words,
// plus backpressure, long-frame and reset-during-flush sequences.
module tb_pix_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] in_d = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [15:0] out_d;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic        frame_done;
    logic [23:0] frame_pixel_count;

    pix_packer #(.CountWidth(24)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_d(in_d), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_d(out_d), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .frame_done(frame_done), .frame_pixel_count(frame_pixel_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc = 0;
    int n_stall = 0;
    int n_done = 0;
    logic [11:0] pix_q[$];
    logic [16:0] got_q[$];
    logic [16:0] exp_q[$];

    typedef struct {
        int          np;
        logic [4:0][11:0] pix;
        int          nw;
        logic [3:0][15:0] wd;
    } frame_vec_t;
    frame_vec_t tbl[5];

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) got_q.push_back({out_last, out_d});
            if (in_valid && in_ready) n_acc++;
            if (in_valid && !in_ready) n_stall++;
            if (frame_done) n_done++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    task automatic drive_frame(input string nm);
        int n;
        n = pix_q.size();
        for (int i = 0; i < n; i++) begin
            int  budget;
            bit  fired;
            budget = 0;
            fired  = 1'b0;
            in_valid = 1'b1;
            in_d     = pix_q[i];
            in_last  = (i == n - 1);
            while (!fired && budget < 500) begin
                @(negedge clk);
                fired = in_ready;
                @(posedge clk);
                #1;
                budget++;
            end
            if (!fired) begin
                chk({nm, " accept_timeout"}, 32'(i), 32'hFFFF_FFFF);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_d     = 12'($urandom);
    endtask

    task automatic wait_words(input int nw);
        int b;
        b = 0;
        while (got_q.size() < nw && b < 2000) begin
            @(posedge clk);
            b++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic compare_words(input string nm);
        int bad;
        int first;
        bad = 0;
        first = -1;
        chk({nm, " word_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        if (exp_q.size() <= 4) begin
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
                chk($sformatf("%s word%0d {last,d}", nm, i), 32'(got_q[i]), 32'(exp_q[i]));
        end else begin
            if (first >= 0)
                $display("first bad word %0d: got %0h want %0h", first, got_q[first], exp_q[first]);
            chk({nm, " bad_words"}, 32'(bad), 32'd0);
        end
    endtask

    task automatic run_check(input string nm);
        int d0;
        int np;
        np = pix_q.size();
        got_q.delete();
        d0 = n_done;
        drive_frame(nm);
        wait_words(exp_q.size());
        compare_words(nm);
        chk({nm, " frame_done_pulses"}, 32'(n_done - d0), 32'd1);
        chk({nm, " frame_pixel_count"}, 32'(frame_pixel_count), 32'(np));
    endtask

    function automatic void model_pack();
        logic bitq[$];
        logic [15:0] w;
        exp_q.delete();
        foreach (pix_q[i])
            for (int b = 0; b < 12; b++) bitq.push_back(pix_q[i][b]);
        while (bitq.size() > 0) begin
            w = '0;
            for (int b = 0; b < 16; b++)
                if (bitq.size() > 0) w[b] = bitq.pop_front();
            exp_q.push_back({bitq.size() == 0, w});
        end
    endfunction

    task automatic load_vec(input int k);
        pix_q.delete();
        exp_q.delete();
        for (int i = 0; i < tbl[k].np; i++) pix_q.push_back(tbl[k].pix[i]);
        for (int i = 0; i < tbl[k].nw; i++) exp_q.push_back({i == tbl[k].nw - 1, tbl[k].wd[i]});
    endtask

    initial begin
        tbl[0].np = 4; tbl[0].pix = {12'h0, 12'hABC, 12'h789, 12'h456, 12'h123};
        tbl[0].nw = 3; tbl[0].wd  = {16'h0, 16'hABC7, 16'h8945, 16'h6123};
        tbl[1].np = 1; tbl[1].pix = {12'h0, 12'h0, 12'h0, 12'h0, 12'hFFF};
        tbl[1].nw = 1; tbl[1].wd  = {16'h0, 16'h0, 16'h0, 16'h0FFF};
        tbl[2].np = 5; tbl[2].pix = {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        tbl[2].nw = 4; tbl[2].wd  = {16'h0FFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        tbl[3].np = 2; tbl[3].pix = {12'h0, 12'h0, 12'h0, 12'h123, 12'hABC};
        tbl[3].nw = 2; tbl[3].wd  = {16'h0, 16'h0, 16'h0012, 16'h3ABC};
        tbl[4].np = 3; tbl[4].pix = {12'h0, 12'h0, 12'h003, 12'h002, 12'h001};
        tbl[4].nw = 3; tbl[4].wd  = {16'h0, 16'h0000, 16'h0300, 16'h2001};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_d", 32'(out_d), 32'd0);
        chk("rst out_last", 32'(out_last), 32'd0);
        chk("rst frame_done", 32'(frame_done), 32'd0);
        chk("rst frame_pixel_count", 32'(frame_pixel_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-rst in_ready", 32'(in_ready), 32'd1);

        for (int k = 0; k < 5; k++) begin
            load_vec(k);
            run_check($sformatf("vec%0d", k));
        end

        // backpressure: only 3 pixels fit while the sink is stalled
        pix_q = '{12'h111, 12'h222, 12'h333, 12'h444};
        exp_q = '{17'h0_2111, 17'h0_3322, 17'h1_4443};
        got_q.delete();
        out_ready = 1'b0;
        fork
            drive_frame("bp");
            begin
                int a0;
                int unstable;
                a0 = n_acc;
                unstable = 0;
                repeat (4) @(negedge clk);
                for (int c = 0; c < 8; c++) begin
                    @(negedge clk);
                    if (out_d !== 16'h2111 || out_valid !== 1'b1 || out_last !== 1'b0) unstable++;
                end
                chk("bp accepted", 32'(n_acc - a0), 32'd3);
                chk("bp in_ready", 32'(in_ready), 32'd0);
                chk("bp unstable_cycles", 32'(unstable), 32'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_words(3);
        compare_words("bp");
        chk("bp frame_pixel_count", 32'(frame_pixel_count), 32'd4);

        // long frame back-to-back
        pix_q.delete();
        for (int i = 0; i < 1024; i++) pix_q.push_back(12'((i * 37 + 5) & 12'hFFF));
        model_pack();
        begin
            int s0;
            s0 = n_stall;
            run_check("long");
            chk("long stalls", 32'(n_stall - s0), 32'd0);
            chk("long exp_words", 32'(exp_q.size()), 32'd768);
        end

        // reset during flush with two words pending
        pix_q = '{12'h5A5, 12'h3C3};
        out_ready = 1'b0;
        drive_frame("abort");
        @(posedge clk);
        #1;
        chk("abort pending out_valid", 32'(out_valid), 32'd1);
        chk("abort pending in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort out_d", 32'(out_d), 32'd0);
        chk("abort out_last", 32'(out_last), 32'd0);
        chk("abort frame_pixel_count", 32'(frame_pixel_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        got_q.delete();
        repeat (4) @(posedge clk);
        #1;
        chk("abort leftover words", 32'(got_q.size()), 32'd0);
        load_vec(0);
        run_check("after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
